// File: rtl/booth_mult32_seq.sv
// Sequential signed NxN radix-4 Booth multiplier, N/2 iteration cycles.
// start/busy/done handshake; product held until the next accepted start.
module booth_mult32_seq #(
    parameter int N = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = (N > 2) ? $clog2(N / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [N+1:0]  mx;
    logic [N+1:0]  a;
    logic [N-1:0]  qr;
    logic          qm1;
    logic [CW-1:0] cnt;

    logic [N+1:0]  term;
    logic [N+1:0]  sum;
    logic [N+1:0]  a_n;
    logic [N-1:0]  qr_n;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Two guard bits keep the +/-2M term and the running sum exact.
    always_comb begin
        term = '0;
        case ({qr[1:0], qm1})
            3'b001, 3'b010: term = mx;
            3'b011:         term = {mx[N:0], 1'b0};
            3'b100:         term = -{mx[N:0], 1'b0};
            3'b101, 3'b110: term = -mx;
            default:        term = '0;
        endcase
        sum  = a + term;
        a_n  = {{2{sum[N+1]}}, sum[N+1:2]};
        qr_n = {sum[1:0], qr[N-1:2]};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mx      <= '0;
            a       <= '0;
            qr      <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mx  <= {{2{multiplicand[N-1]}}, multiplicand};
                        a   <= '0;
                        qr  <= multiplier;
                        qm1 <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    a   <= a_n;
                    qr  <= qr_n;
                    qm1 <= qr[1];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= {a_n[N-1:0], qr_n};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/booth_mult32_seq.md
Name: booth_mult32_seq

Overview:
- Sequential signed 32x32 multiplier using radix-4 (bit-pair) Booth recoding. Produces a 64-bit two's-complement product in 16 iteration cycles.
- Companion to the ALU divider; feeds the HI/LO product path of the ALU.
- Uses a start/busy/done handshake so the control unit can stall for the multi-cycle MUL instruction.

Parameters:
- N, 32, operand width; must be even; product is 2N bits; iteration count is N/2.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- multiplicand  in  N  signed operand M
- multiplier  in  N  signed operand Q
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  one-cycle pulse; product valid in the same cycle
- product  out  2N  signed result {HI, LO}; held until the next accepted start

Behaviour:
- Reset: clear asserted at any time gives state=IDLE, busy=0, done=0, product=0, all internal registers=0, iteration counter=0. An in-flight operation is abandoned; no done pulse is produced for it.
- States: IDLE, RUN, DONE.
  - IDLE->RUN on start=1. At that edge:
    - latch M into a 2-bit-sign-extended register Mx (N+2 bits).
    - A := 0 (N+2 bits), Qr := multiplier, q_m1 := 0, counter := 0.
  - RUN: one Booth step per cycle. Exit to DONE after step N/2-1 (counter==N/2-1).
  - DONE: lasts exactly one cycle; returns to IDLE unconditionally.
- Booth step: examine {Qr[1], Qr[0], q_m1}.
  - 000 or 111: add 0
  - 001 or 010: add +M
  - 011: add +2M
  - 100: add -2M
  - 101 or 110: add -M
  - Add in N+2-bit two's complement: A := A + term.
  - Then arithmetic-shift {A, Qr, q_m1} right by 2. A's MSB is replicated.
- Result: product := {A[N-1:0], Qr}. It is registered on the RUN->DONE edge, so it is valid while done=1 and remains stable afterwards.
- Timing, with start accepted at edge 0:
  - busy=1 for cycles 1..16.
  - done=1 in cycle 17.
  - busy=0 in the done cycle.
  - Latency from accept to done is 17 cycles.
- Handshake rules:
  - start while busy or done is ignored; operands are not re-sampled.
  - Operand inputs may change freely after the accept edge.
  - start held high continuously is re-accepted on the first IDLE cycle after DONE, giving 18-cycle back-to-back throughput.
- Boundary cases:
  - The -2^N-1 x -2^N-1 result must be +2^(2N-2) exactly. The N+2-bit accumulator guarantees no overflow of the ±2M term.
  - Zero operand: product 0, still 17-cycle latency. There is no early termination.
- No combinational path from any input to any output.

Test Plan:
- Basic signed: reset, then start with multiplicand=7, multiplier=-3 (0xFFFFFFFD) -> busy for 16 cycles, done at cycle 17, product=64'hFFFF_FFFF_FFFF_FFEB.
- Extremes:
  - 0x80000000 x 0x80000000 -> product=64'h4000_0000_0000_0000.
  - 0x7FFFFFFF x 0x80000000 -> 64'hC000_0000_8000_0000.
- Sign and identity: 0xFFFFFFFF x 1 -> 64'hFFFF_FFFF_FFFF_FFFF. 0x12345678 x 0 -> 0. 0x0001_0000 x 0x0001_0000 -> 64'h0000_0001_0000_0000.
- Start during busy: accept 5x6. Pulse start with 9x9 at cycle 8 -> ignored; done at cycle 17 with product=30. No second done follows.
- Reset mid-operation: accept 100x100, assert clear at cycle 10 -> busy=0, done=0, product=0 immediately, and no done pulse appears. After release, accept 3x4 -> product=12 at 17 cycles.
- Back-to-back: hold start=1 with 2x3, then 4x5 (operands switched after the first accept) -> done pulses 18 cycles apart with products 6 then 20. The product holds 6 between the two pulses.
